sync_delay_line: RTL

SYNC_DELAY_LINE -- requirements
Module: sync_delay_line

---
 rtl/sync_delay_pkg.sv | 20 ++
 rtl/sync_dff_stage.sv | 45 ++++
 rtl/sync_delay_line.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sync_delay_pkg.sv
// ---------------------------------------------------------------------------
// sync_delay_pkg
// Shared constants and helpers for the sync_delay_line block.
//   DEFAULT_WIDTH     : default data bits per stage
//   DEFAULT_DEPTH     : default number of register stages
//   DEFAULT_RESET_VAL : default value loaded into data stages on reset/clear
//   fill_width()      : bit width needed to hold an occupancy count 0..depth
// ---------------------------------------------------------------------------
package sync_delay_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 1;
  localparam int unsigned DEFAULT_DEPTH     = 2;
  localparam int unsigned DEFAULT_RESET_VAL = 0;

  // Width of the occupancy counter: must represent 0..depth inclusive.
  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage : sync_delay_pkg

// File: rtl/sync_dff_stage.sv
// ---------------------------------------------------------------------------
// sync_dff_stage
// One slot of the delay line: a WIDTH-bit data register plus its valid bit.
// Priority per rising edge: RST_n low > CLR high > EN high > hold.
// Ports:
//   CLK      : clock, rising edge
//   RST_n    : synchronous active-low reset
//   EN       : load enable
//   CLR      : synchronous flush to RESET_VAL / invalid
//   D        : data in
//   VLD_IN   : valid bit in
//   Q        : registered data out
//   VLD_OUT  : registered valid bit out
// ---------------------------------------------------------------------------
module sync_dff_stage
  import sync_delay_pkg::*;
#(
  parameter int unsigned          WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]     RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             VLD_IN,
  output logic [WIDTH-1:0] Q,
  output logic             VLD_OUT
);

  // Data and valid travel together; reset and clear share one outcome.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      Q       <= RESET_VAL;
      VLD_OUT <= 1'b0;
    end else if (CLR) begin
      Q       <= RESET_VAL;
      VLD_OUT <= 1'b0;
    end else if (EN) begin
      Q       <= D;
      VLD_OUT <= VLD_IN;
    end
  end

endmodule : sync_dff_stage

// File: rtl/sync_delay_line.sv
// ---------------------------------------------------------------------------
// sync_delay_line
// Enable-gated shift register of DEPTH stages, each carrying WIDTH data bits
// and a valid bit, with a registered occupancy counter.
// Optional feature macro: SYNC_DELAY_LINE_TAPS_EN adds TAPS/TAPS_VLD outputs
// exposing every stage (stage i at TAPS[i*WIDTH +: WIDTH]).
// Ports:
//   CLK      : clock, all state updates on rising edge
//   RST_n    : synchronous active-low reset
//   EN       : shift enable (0 = hold everything)
//   CLR      : synchronous flush of all stages, valid bits and FILL
//   D        : data into stage 0
//   VLD_IN   : valid qualifier for D
//   Q        : data of stage DEPTH-1
//   VLD_OUT  : valid bit of stage DEPTH-1
//   FILL     : number of valid stages, 0..DEPTH
//   FULL     : FILL == DEPTH
//   TAPS     : (macro only) all stage data
//   TAPS_VLD : (macro only) all stage valid bits
// ---------------------------------------------------------------------------
module sync_delay_line
  import sync_delay_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned      DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input  logic                           CLK,
  input  logic                           RST_n,
  input  logic                           EN,
  input  logic                           CLR,
  input  logic [WIDTH-1:0]               D,
  input  logic                           VLD_IN,
  output logic [WIDTH-1:0]               Q,
  output logic                           VLD_OUT,
  output logic [fill_width(DEPTH)-1:0]   FILL,
  output logic                           FULL
`ifdef SYNC_DELAY_LINE_TAPS_EN
  ,
  output logic [DEPTH*WIDTH-1:0]         TAPS,
  output logic [DEPTH-1:0]               TAPS_VLD
`endif
);

  localparam int unsigned FW = fill_width(DEPTH);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_vld;

  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_next;
  logic          full_q;
  logic          full_next;

  // Stage chain: stage 0 takes the inputs, each later stage its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (i == 0) begin : g_head
      assign d_in = D;
      assign v_in = VLD_IN;
    end else begin : g_body
      assign d_in = stage_data[i-1];
      assign v_in = stage_vld[i-1];
    end

    sync_dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .CLK     (CLK),
      .RST_n   (RST_n),
      .EN      (EN),
      .CLR     (CLR),
      .D       (d_in),
      .VLD_IN  (v_in),
      .Q       (stage_data[i]),
      .VLD_OUT (stage_vld[i])
    );

`ifdef SYNC_DELAY_LINE_TAPS_EN
    assign TAPS[i*WIDTH +: WIDTH] = stage_data[i];
    assign TAPS_VLD[i]            = stage_vld[i];
`endif
  end

  assign Q       = stage_data[DEPTH-1];
  assign VLD_OUT = stage_vld[DEPTH-1];

  // Occupancy update: one word may enter and one may leave per enabled edge;
  // when both happen (or neither) the count is unchanged, which keeps it
  // pinned at DEPTH when full-and-streaming and at 0 when empty-and-idle.
  always_comb begin
    fill_next = fill_q;
    full_next = full_q;
    if (EN) begin
      unique case ({VLD_IN, stage_vld[DEPTH-1]})
        2'b10:   fill_next = fill_q + FW'(1);
        2'b01:   fill_next = fill_q - FW'(1);
        default: fill_next = fill_q;
      endcase
      full_next = (fill_next == FW'(DEPTH));
    end
  end

  // FULL is registered alongside FILL so it has no path from the inputs.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else if (CLR) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_next;
      full_q <= full_next;
    end
  end

  assign FILL = fill_q;
  assign FULL = full_q;

endmodule : sync_delay_line
